// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage MIPS pipe: load-use, branch, jump, MDU occupancy, memory waits.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int MDU_LATENCY = 4,
  parameter int RA_W        = 5
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [RA_W-1:0] ID_Rs,
  input  logic [RA_W-1:0] ID_Rt,
  input  logic            ID_UsesRt,
  input  logic            ID_Jump,
  input  logic            EX_MemRead,
  input  logic [RA_W-1:0] EX_Rt,
  input  logic            EX_BranchTaken,
  input  logic            EX_MduStart,
  input  logic            MemStall,
  output logic            PCWrite,
  output logic            IFIDWrite,
  output logic            IDEXWrite,
  output logic            EXMEMWrite,
  output logic            MEMWBWrite,
  output logic            IFIDFlush,
  output logic            IDEXFlush,
  output logic            EXMEMFlush,
  output logic            Busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]     StallCount,
  output logic [31:0]     FlushCount
`endif
);

  typedef enum logic {RUN, MDU_BUSY} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MDU_LATENCY - 2);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       done, done_nxt;
  logic       lu, ms, last;

  // done marks the one normal cycle after an MDU stall in which the (still
  // asserted) EX_MduStart belongs to the finishing op and must not restart it.
  always_comb begin
    lu = EX_MemRead && (EX_Rt != '0) &&
         ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));
    ms = ((state == RUN) && EX_MduStart && !done && (MDU_LATENCY > 1)) ||
         (state == MDU_BUSY);
    last = (state == MDU_BUSY) ? (cnt == 4'd1) : (MDU_LATENCY == 2);

    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = done;
    if (!MemStall) begin
      done_nxt = ms && last;
      case (state)
        RUN:
          if (EX_MduStart && !done && (MDU_LATENCY > 2)) begin
            state_nxt = MDU_BUSY;
            cnt_nxt   = CNT_INIT;
          end
        MDU_BUSY:
          if (cnt == 4'd1) state_nxt = RUN;
          else             cnt_nxt   = cnt - 4'd1;
        default: state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IDEXWrite  = 1'b1;
    EXMEMWrite = 1'b1;
    MEMWBWrite = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXFlush  = 1'b0;
    EXMEMFlush = 1'b0;
    Busy       = Rst && ms;
    if (!Rst) begin
      PCWrite    = 1'b0;
      IFIDFlush  = 1'b1;
      IDEXFlush  = 1'b1;
      EXMEMFlush = 1'b1;
    end else if (MemStall) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXWrite  = 1'b0;
      EXMEMWrite = 1'b0;
      MEMWBWrite = 1'b0;
    end else if (ms) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXWrite  = 1'b0;
      EXMEMFlush = 1'b1;
    end else if (EX_BranchTaken) begin
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
    end else if (lu) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IDEXFlush = 1'b1;
    end else if (ID_Jump) begin
      IFIDFlush = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= RUN;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (!PCWrite) StallCount <= StallCount + 32'd1;
      if (IFIDFlush || IDEXFlush || EXMEMFlush) FlushCount <= FlushCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl with MDU_LATENCY of 4, 1 and 2.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, id_jump, ex_mem_read, ex_branch, ex_mdu, mem_stall;

  // {PC,IFID,IDEX,EXMEM,MEMWB writes | IFID,IDEX,EXMEM flushes | Busy}
  logic [8:0] c4, c1, c2;
  int pass_cnt = 0;
  int total    = 0;

  localparam logic [8:0] NORM = 9'b11111_000_0;
  localparam logic [8:0] RSTV = 9'b01111_111_0;
  localparam logic [8:0] MDUS = 9'b00011_001_1;
  localparam logic [8:0] BRV  = 9'b11111_110_0;
  localparam logic [8:0] LUV  = 9'b00111_010_0;
  localparam logic [8:0] JMPV = 9'b11111_100_0;
  localparam logic [8:0] MSTL = 9'b00000_000_1;

  always #5 clk = ~clk;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] sc4, fc4, sc1, fc1, sc2, fc2;
`endif

  pipeline_hazard_ctrl #(.MDU_LATENCY(4), .RA_W(5)) u_dut4 (
    .Clk(clk), .Rst(rst), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRt(id_uses_rt),
    .ID_Jump(id_jump), .EX_MemRead(ex_mem_read), .EX_Rt(ex_rt),
    .EX_BranchTaken(ex_branch), .EX_MduStart(ex_mdu), .MemStall(mem_stall),
    .PCWrite(c4[8]), .IFIDWrite(c4[7]), .IDEXWrite(c4[6]), .EXMEMWrite(c4[5]),
    .MEMWBWrite(c4[4]), .IFIDFlush(c4[3]), .IDEXFlush(c4[2]), .EXMEMFlush(c4[1]),
    .Busy(c4[0])
`ifdef HAZARD_PERF_CNT_EN
    , .StallCount(sc4), .FlushCount(fc4)
`endif
  );

  pipeline_hazard_ctrl #(.MDU_LATENCY(1), .RA_W(5)) u_dut1 (
    .Clk(clk), .Rst(rst), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRt(id_uses_rt),
    .ID_Jump(id_jump), .EX_MemRead(ex_mem_read), .EX_Rt(ex_rt),
    .EX_BranchTaken(ex_branch), .EX_MduStart(ex_mdu), .MemStall(mem_stall),
    .PCWrite(c1[8]), .IFIDWrite(c1[7]), .IDEXWrite(c1[6]), .EXMEMWrite(c1[5]),
    .MEMWBWrite(c1[4]), .IFIDFlush(c1[3]), .IDEXFlush(c1[2]), .EXMEMFlush(c1[1]),
    .Busy(c1[0])
`ifdef HAZARD_PERF_CNT_EN
    , .StallCount(sc1), .FlushCount(fc1)
`endif
  );

  pipeline_hazard_ctrl #(.MDU_LATENCY(2), .RA_W(5)) u_dut2 (
    .Clk(clk), .Rst(rst), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRt(id_uses_rt),
    .ID_Jump(id_jump), .EX_MemRead(ex_mem_read), .EX_Rt(ex_rt),
    .EX_BranchTaken(ex_branch), .EX_MduStart(ex_mdu), .MemStall(mem_stall),
    .PCWrite(c2[8]), .IFIDWrite(c2[7]), .IDEXWrite(c2[6]), .EXMEMWrite(c2[5]),
    .MEMWBWrite(c2[4]), .IFIDFlush(c2[3]), .IDEXFlush(c2[2]), .EXMEMFlush(c2[1]),
    .Busy(c2[0])
`ifdef HAZARD_PERF_CNT_EN
    , .StallCount(sc2), .FlushCount(fc2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rt = 0; id_jump = 0; ex_mem_read = 0; ex_branch = 0; ex_mdu = 0; mem_stall = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    tick(); tick();
    total++; if (c4 !== RSTV) $display("FAIL reset_lat4 got %b want %b", c4, RSTV); else pass_cnt++;
    total++; if (c1 !== RSTV) $display("FAIL reset_lat1 got %b want %b", c1, RSTV); else pass_cnt++;
    total++; if (c2 !== RSTV) $display("FAIL reset_lat2 got %b want %b", c2, RSTV); else pass_cnt++;
    rst = 1'b1;
    tick();
    total++; if (c4 !== NORM) $display("FAIL post_reset got %b want %b", c4, NORM); else pass_cnt++;
  endtask

  task automatic test_load_use();
    ex_mem_read = 1; ex_rt = 5'd8; id_rs = 5'd8;
    #1;
    total++; if (c4 !== LUV) $display("FAIL lu_rs got %b want %b", c4, LUV); else pass_cnt++;
    tick();
    idle();
    #1;
    total++; if (c4 !== NORM) $display("FAIL lu_after got %b want %b", c4, NORM); else pass_cnt++;
    ex_mem_read = 1; ex_rt = 5'd0; id_rs = 5'd0;
    #1;
    total++; if (c4 !== NORM) $display("FAIL lu_r0 got %b want %b", c4, NORM); else pass_cnt++;
    ex_rt = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 0;
    #1;
    total++; if (c4 !== NORM) $display("FAIL lu_rt_unused got %b want %b", c4, NORM); else pass_cnt++;
    id_uses_rt = 1;
    #1;
    total++; if (c4 !== LUV) $display("FAIL lu_rt_used got %b want %b", c4, LUV); else pass_cnt++;
    tick();
    idle();
  endtask

  task automatic test_jump_branch();
    id_jump = 1;
    #1;
    total++; if (c4 !== JMPV) $display("FAIL jump got %b want %b", c4, JMPV); else pass_cnt++;
    ex_branch = 1; ex_mem_read = 1; ex_rt = 5'd8; id_rs = 5'd8;
    #1;
    total++; if (c4 !== BRV) $display("FAIL branch_over_lu got %b want %b", c4, BRV); else pass_cnt++;
    tick();
    idle();
  endtask

  task automatic test_mdu();
    ex_mdu = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (c4 !== ((i < 3) ? MDUS : NORM)) $display("FAIL mdu4_cyc%0d got %b want %b", i, c4, (i < 3) ? MDUS : NORM);
      else pass_cnt++;
      if (i == 0) begin
        total++; if (c1 !== NORM) $display("FAIL mdu1_cyc0 got %b want %b", c1, NORM); else pass_cnt++;
      end
      if (i < 2) begin
        total++;
        if (c2 !== ((i == 0) ? MDUS : NORM)) $display("FAIL mdu2_cyc%0d got %b want %b", i, c2, (i == 0) ? MDUS : NORM);
        else pass_cnt++;
      end
      tick();
    end
    idle();
    #1;
    total++; if (c4 !== NORM) $display("FAIL mdu4_after got %b want %b", c4, NORM); else pass_cnt++;
  endtask

  task automatic test_memstall_mdu();
    int stalls = 0;
    ex_mdu = 1;
    for (int i = 0; i < 6; i++) begin
      logic [8:0] exp;
      mem_stall = (i == 1 || i == 2);
      exp = (i == 5) ? NORM : (mem_stall ? MSTL : MDUS);
      #1;
      if (c4[8] === 1'b0) stalls++;
      total++;
      if (c4 !== exp) $display("FAIL mstall_cyc%0d got %b want %b", i, c4, exp); else pass_cnt++;
      tick();
    end
    idle();
    total++; if (stalls !== 5) $display("FAIL mstall_total got %0d want 5", stalls); else pass_cnt++;
  endtask

  task automatic test_reset_mid_mdu();
    ex_mdu = 1;
    tick();
    rst = 1'b0;
    #1;
    total++; if (c4 !== RSTV) $display("FAIL rstmid_during got %b want %b", c4, RSTV); else pass_cnt++;
    tick();
    rst = 1'b1;
    ex_mdu = 0;
    #1;
    total++; if (c4 !== NORM) $display("FAIL rstmid_after got %b want %b", c4, NORM); else pass_cnt++;
    tick();
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    rst = 1'b0; idle(); tick();
    rst = 1'b1; tick();
    ex_mem_read = 1; ex_rt = 5'd8; id_rs = 5'd8; tick();
    idle(); ex_branch = 1; tick();
    idle(); tick();
    total++; if (sc4 !== 32'd1) $display("FAIL perf_stall got %0d want 1", sc4); else pass_cnt++;
    total++; if (fc4 !== 32'd2) $display("FAIL perf_flush got %0d want 2", fc4); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_jump_branch();
    test_mdu();
    test_memstall_mdu();
    test_reset_mid_mdu();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage pipelined MIPS core. It drives the `Write` enables and bubble-insert (flush) controls of every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). It detects load-use hazards, taken branches, jumps, multi-cycle multiply/divide occupancy and memory wait states. It holds a small FSM and counter so that a multi-cycle EX operation freezes the front of the pipe for exactly the required number of cycles.

## Interface
Parameters:
- `MDU_LATENCY`, 4: cycles a mult/div occupies EX; legal 1..16.
- `RA_W`, 5: register address width.

Ports:
- `Clk` in 1: clock; all state updates on the rising edge.
- `Rst` in 1: synchronous, active-low reset.
- `ID_Rs`, `ID_Rt` in `RA_W`: source registers of the instruction in ID.
- `ID_UsesRt` in 1: the ID instruction reads `ID_Rt`.
- `ID_Jump` in 1: the ID instruction is j/jal/jr.
- `EX_MemRead` in 1: the EX instruction is a load.
- `EX_Rt` in `RA_W`: load destination in EX.
- `EX_BranchTaken` in 1: the branch in EX resolved taken.
- `EX_MduStart` in 1: the EX instruction is mult/div. Stays high while that instruction is held.
- `MemStall` in 1: the data/instruction memory is not ready.
- `PCWrite`, `IFIDWrite`, `IDEXWrite`, `EXMEMWrite`, `MEMWBWrite` out 1: register write enables.
- `IFIDFlush`, `IDEXFlush`, `EXMEMFlush` out 1: load a bubble (all-zero control) instead of `in`.
- `Busy` out 1: MDU occupancy in progress.

## Operation
- FSM states: `RUN`, `MDU_BUSY`. There is a 4-bit down-counter `cnt`.
- Load-use hazard, `LU`: `EX_MemRead && EX_Rt != 0 && (EX_Rt == ID_Rs || (ID_UsesRt && EX_Rt == ID_Rt))`.
- MDU stall, `MS`: `(RUN && EX_MduStart && MDU_LATENCY > 1) || MDU_BUSY`.
- Priority, highest first. Default is all Write = 1, all Flush = 0.
  1. `MemStall`: every Write = 0 and every Flush = 0. FSM and `cnt` are frozen.
  2. `MS`: `PCWrite`, `IFIDWrite` and `IDEXWrite` = 0. `EXMEMFlush` = 1, which sends a bubble to MEM. MEM/WB writes normally.
  3. `EX_BranchTaken`: `IFIDFlush` = 1 and `IDEXFlush` = 1; PC loads the target. This overrides `LU` and `ID_Jump`, because those instructions are squashed.
  4. `LU`: `PCWrite` = 0 and `IFIDWrite` = 0; `IDEXFlush` = 1, giving one bubble.
  5. `ID_Jump`: `IFIDFlush` = 1.
- FSM transitions (only when `MemStall` = 0):
  - `RUN` → `MDU_BUSY` on `EX_MduStart` when `MDU_LATENCY > 2`, with `cnt` ← `MDU_LATENCY-2`.
  - In `MDU_BUSY`: if `cnt` == 1, go to `RUN`; otherwise decrement `cnt`.
  - `EX_MduStart` is ignored in `MDU_BUSY`.
- The number of MDU stall cycles is exactly `MDU_LATENCY-1`. The cycle after the last stall cycle is normal, and EX/MEM captures the result.
- With `MDU_LATENCY` == 1 there is no stall. With `MDU_LATENCY` == 2 there is one stall cycle and the FSM never enters `MDU_BUSY`.
- `Busy` = `MS`.
- Reset (`Rst` = 0 at an edge):
  - State is set to `RUN` and `cnt` to 0, including mid-MDU.
  - While `Rst` = 0, outputs are forced: `PCWrite` = 0, all other Write = 1, all Flush = 1, `Busy` = 0. This fills the pipe with bubbles.

## Timing
- All outputs are combinational from the current inputs and the registered state. There is zero cycle latency from a hazard input to a control output.
- State changes are visible in the cycle after the edge.
- The block adds no pipeline stage. Outputs must settle before the pipeline registers' rising edge.
- `MemStall` may arrive in any cycle, including mid-MDU. It extends the MDU stall by the number of `MemStall` cycles.

## Configuration
- `HAZARD_PERF_CNT_EN`:
  - When defined, the block adds outputs `StallCount` (32 bits) and `FlushCount` (32 bits), both reset to 0.
  - `StallCount` increments in every cycle where `PCWrite` = 0 and `Rst` = 1.
  - `FlushCount` increments in every cycle where any Flush = 1 and `Rst` = 1.
  - Both counters wrap modulo 2^32.
- When undefined, the ports and counters are absent and the rest of the behaviour is identical.

## Test plan
- Load-use: `EX_MemRead` = 1, `EX_Rt` = 8, `ID_Rs` = 8 → one cycle of `PCWrite` = 0, `IFIDWrite` = 0, `IDEXFlush` = 1. `EX_Rt` = 0 gives no stall.
- MDU: `MDU_LATENCY` = 4 and `EX_MduStart` held high → `PCWrite` = 0 and `Busy` = 1 for exactly 3 cycles, then normal. Repeat with `MDU_LATENCY` = 1 (no stall) and 2 (one stall cycle).
- Branch and load-use together: `EX_BranchTaken` = 1 with a `LU` hit → `IFIDFlush` = 1, `IDEXFlush` = 1, `PCWrite` = 1.
- `MemStall` mid-MDU: `MDU_LATENCY` = 4, `MemStall` high for 2 cycles during the second stall cycle → total of 5 cycles with `PCWrite` = 0. All Write = 0 during `MemStall`.
- Reset mid-MDU: `Rst` = 0 during `MDU_BUSY` → next cycle is `RUN` with `Busy` = 0. During reset all Flush = 1 and `PCWrite` = 0.
- With `HAZARD_PERF_CNT_EN` defined: after one load-use stall and one taken branch → `StallCount` = 1, `FlushCount` = 2.
